// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the OPC5 serial boot loader.
package boot_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ADDR_H = 4'd1,
        S_ADDR_L = 4'd2,
        S_LEN_H  = 4'd3,
        S_LEN_L  = 4'd4,
        S_DATA_H = 4'd5,
        S_DATA_L = 4'd6,
        S_CSUM   = 4'd7,
        S_RUN    = 4'd8
    } state_e;

    localparam logic [7:0] DEFAULT_SYNC    = 8'hA5;
    localparam int         DEFAULT_TIMEOUT = 3200000;

    // Width needed to hold the counter value TIMEOUT itself.
    function automatic int timer_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int TIMER_W = timer_width(DEFAULT_TIMEOUT);

endpackage

// File: rtl/boot_loader_if.sv
// Byte-receive input and RAM/CPU-control output bundle of the boot loader.
interface boot_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] mem_addr;
    logic [15:0] mem_dout;
    logic        mem_we;
    logic        cpu_hold;
    logic        load_error;
    logic        load_done;

    modport master (
        input  rx_data, rx_valid,
        output mem_addr, mem_dout, mem_we, cpu_hold, load_error, load_done
    );

    modport slave (
        output rx_data, rx_valid,
        input  mem_addr, mem_dout, mem_we, cpu_hold, load_error, load_done
    );
endinterface

// File: rtl/boot_timer.sv
// Inter-byte timeout counter: expires in the TIMEOUT-th enabled cycle since the last clear.
module boot_timer #(
    parameter int TIMEOUT = 3200000,
    parameter int W       = 22
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [W-1:0] cnt_r;

    // Counter register: cleared on accepted byte or while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clear || !enable) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + W'(1);
        end
    end

    assign expired = enable && (cnt_r == W'(TIMEOUT - 1));
endmodule

// File: rtl/boot_loader.sv
// Frame decoder that writes loaded words to RAM and releases the CPU on a good terminating frame.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter logic [7:0] SYNC    = DEFAULT_SYNC,
    parameter int         TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    boot_loader_if.master bus
);
    localparam int TW = timer_width(TIMEOUT);

    state_e      state_r, state_n;
    logic [15:0] addr_r, addr_n;
    logic [15:0] cnt_r, cnt_n;
    logic [7:0]  sum_r, sum_n;
    logic [7:0]  hi_r, hi_n;
    logic        term_r, term_n;
    logic [15:0] mem_addr_r, mem_addr_n;
    logic [15:0] mem_dout_r, mem_dout_n;
    logic        mem_we_r, mem_we_n;
    logic        hold_r, hold_n;
    logic        err_r, err_n;
    logic        done_r, done_n;

    logic [7:0]  sum_next_s;
    logic [15:0] len_s;
    logic        timer_en_s;
    logic        expired_s;

    assign sum_next_s = sum_r + bus.rx_data;
    assign len_s      = {cnt_r[15:8], bus.rx_data};
    assign timer_en_s = (state_r != S_IDLE) && (state_r != S_RUN);

    boot_timer #(.TIMEOUT(TIMEOUT), .W(TW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.rx_valid),
        .enable  (timer_en_s),
        .expired (expired_s)
    );

    // Next-state and datapath decode; an accepted byte takes priority over expiry.
    always_comb begin
        state_n    = state_r;
        addr_n     = addr_r;
        cnt_n      = cnt_r;
        sum_n      = sum_r;
        hi_n       = hi_r;
        term_n     = term_r;
        mem_addr_n = mem_addr_r;
        mem_dout_n = mem_dout_r;
        mem_we_n   = 1'b0;
        hold_n     = hold_r;
        err_n      = err_r;
        done_n     = done_r;
        if (bus.rx_valid) begin
            case (state_r)
                S_IDLE: begin
                    if (bus.rx_data == SYNC) begin
                        sum_n   = 8'h00;
                        state_n = S_ADDR_H;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                S_ADDR_H: begin
                    addr_n[15:8] = bus.rx_data;
                    sum_n        = sum_next_s;
                    state_n      = S_ADDR_L;
                end
                S_ADDR_L: begin
                    addr_n[7:0] = bus.rx_data;
                    sum_n       = sum_next_s;
                    state_n     = S_LEN_H;
                end
                S_LEN_H: begin
                    cnt_n[15:8] = bus.rx_data;
                    sum_n       = sum_next_s;
                    state_n     = S_LEN_L;
                end
                S_LEN_L: begin
                    cnt_n   = len_s;
                    sum_n   = sum_next_s;
                    term_n  = (len_s == 16'h0000);
                    state_n = (len_s == 16'h0000) ? S_CSUM : S_DATA_H;
                end
                S_DATA_H: begin
                    hi_n    = bus.rx_data;
                    sum_n   = sum_next_s;
                    state_n = S_DATA_L;
                end
                S_DATA_L: begin
                    mem_we_n   = 1'b1;
                    mem_addr_n = addr_r;
                    mem_dout_n = {hi_r, bus.rx_data};
                    addr_n     = addr_r + 16'd1;
                    cnt_n      = cnt_r - 16'd1;
                    sum_n      = sum_next_s;
                    state_n    = (cnt_r == 16'd1) ? S_CSUM : S_DATA_H;
                end
                S_CSUM: begin
                    if (sum_next_s != 8'h00) begin
                        err_n   = 1'b1;
                        state_n = S_IDLE;
                    end else if (term_r) begin
                        hold_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = S_RUN;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                S_RUN: begin
                    state_n = S_RUN;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end else if (expired_s) begin
            err_n   = 1'b1;
            state_n = S_IDLE;
        end else begin
            state_n = state_r;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            addr_r     <= 16'h0000;
            cnt_r      <= 16'h0000;
            sum_r      <= 8'h00;
            hi_r       <= 8'h00;
            term_r     <= 1'b0;
            mem_addr_r <= 16'h0000;
            mem_dout_r <= 16'h0000;
            mem_we_r   <= 1'b0;
            hold_r     <= 1'b1;
            err_r      <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            addr_r     <= addr_n;
            cnt_r      <= cnt_n;
            sum_r      <= sum_n;
            hi_r       <= hi_n;
            term_r     <= term_n;
            mem_addr_r <= mem_addr_n;
            mem_dout_r <= mem_dout_n;
            mem_we_r   <= mem_we_n;
            hold_r     <= hold_n;
            err_r      <= err_n;
            done_r     <= done_n;
        end
    end

    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_dout   = mem_dout_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.cpu_hold   = hold_r;
    assign bus.load_error = err_r;
    assign bus.load_done  = done_r;
endmodule
